// File: rtl/mem_arb_pkg.sv
// Shared types and address helpers for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} stateT;
    typedef enum logic [1:0] {OWN_I_RD, OWN_D_RD, OWN_D_WR} ownerT;

    localparam int DEF_LINE_W = 128;
    localparam int OFFS_BITS  = $clog2(DEF_LINE_W / 8);

    // Clear the low offsBits bits of a byte address (line alignment).
    function automatic logic [31:0] alignAddr(input logic [31:0] addr, input int offsBits);
        logic [31:0] mask;
        mask = ~((32'd1 << offsBits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant select: D writes first, then round-robin between I and D reads.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  iReq,
    input  logic  dRdReq,
    input  logic  dWrReq,
    input  logic  lastGrantD,
    output ownerT grant,
    output logic  anyReq,
    output logic  conflict
);

    always_comb begin
        grant    = OWN_D_RD;
        anyReq   = iReq | dRdReq | dWrReq;
        conflict = iReq & (dRdReq | dWrReq);
        if (dWrReq) begin
            grant = OWN_D_WR;
        end else if (iReq && dRdReq) begin
            grant = lastGrantD ? OWN_I_RD : OWN_D_RD;
        end else if (iReq) begin
            grant = OWN_I_RD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache refills and dcache refills/write-throughs.
// Memory handshake: mem_req rises with addr/we/wdata stable and holds until the cycle mem_ready is high; that cycle completes the transfer.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_readmiss,
    input  logic [31:0]       i_addr,
    input  logic              i_abort,
    output logic              i_readready,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_readmiss,
    input  logic              d_writethru,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_readready,
    output logic              d_writeready,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt,
    output stateT             dbgState
);

    localparam int OffsBits = (LINE_W == DEF_LINE_W) ? OFFS_BITS : $clog2(LINE_W / 8);

    stateT             state, stateD;
    ownerT             owner, grant;
    logic              lastGrantD, abortQ;
    logic              iReq, anyReq, conflict;
    logic              grantNow, latchLine, abortSet;
    logic              memWeQ;
    logic [31:0]       memAddrQ, memWdataQ;
    logic [LINE_W-1:0] iRdataQ, dRdataQ;
    logic [CNT_W-1:0]  conflictQ;

    // An icache miss raised together with its own abort never counts as a request.
    assign iReq = i_readmiss & ~i_abort;

    mem_arb_pick u_pick (
        .iReq       (iReq),
        .dRdReq     (d_readmiss),
        .dWrReq     (d_writethru),
        .lastGrantD (lastGrantD),
        .grant      (grant),
        .anyReq     (anyReq),
        .conflict   (conflict)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= stateD;
        end
    end

    always_comb begin
        stateD       = state;
        grantNow     = 1'b0;
        latchLine    = 1'b0;
        abortSet     = 1'b0;
        mem_req      = 1'b0;
        i_readready  = 1'b0;
        d_readready  = 1'b0;
        d_writeready = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    grantNow = 1'b1;
                    stateD   = ISSUE;
                end
            end
            ISSUE: begin
                mem_req  = 1'b1;
                abortSet = i_abort && (owner == OWN_I_RD);
                if (mem_ready) begin
                    latchLine = 1'b1;
                    stateD    = RESP;
                end
            end
            RESP: begin
                i_readready  = (owner == OWN_I_RD) && !abortQ;
                d_readready  = (owner == OWN_D_RD);
                d_writeready = (owner == OWN_D_WR);
                stateD       = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            owner      <= OWN_I_RD;
            lastGrantD <= 1'b1;
            abortQ     <= 1'b0;
            memWeQ     <= 1'b0;
            memAddrQ   <= '0;
            memWdataQ  <= '0;
            iRdataQ    <= '0;
            dRdataQ    <= '0;
            conflictQ  <= '0;
        end else begin
            if (grantNow) begin
                owner     <= grant;
                memWeQ    <= (grant == OWN_D_WR);
                memWdataQ <= d_wdata;
                if (grant == OWN_D_WR) begin
                    memAddrQ <= {d_addr[31:2], 2'b00};
                end else begin
                    memAddrQ   <= alignAddr((grant == OWN_I_RD) ? i_addr : d_addr, OffsBits);
                    lastGrantD <= (grant == OWN_D_RD);
                end
                if (conflict && (conflictQ != '1)) begin
                    conflictQ <= conflictQ + CNT_W'(1);
                end
            end
            if (state == IDLE) begin
                abortQ <= 1'b0;
            end else if (abortSet) begin
                abortQ <= 1'b1;
            end
            // An aborted I refill still completes with memory but its line is discarded.
            if (latchLine) begin
                if (owner == OWN_I_RD) begin
                    if (!(abortQ || abortSet)) begin
                        iRdataQ <= mem_rdata;
                    end
                end else if (owner == OWN_D_RD) begin
                    dRdataQ <= mem_rdata;
                end
            end
        end
    end

    assign mem_we       = memWeQ;
    assign mem_addr     = memAddrQ;
    assign mem_wdata    = memWdataQ;
    assign i_rdata      = iRdataQ;
    assign d_rdata      = dRdataQ;
    assign conflict_cnt = conflictQ;
    assign busy         = (state != IDLE);
    assign dbgState     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory responder tasks, transaction scoreboard, pulse/data checks.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LINE_W = 128;
    localparam int CNT_W  = 2;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              i_readmiss = 1'b0, i_abort = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_readready;
    logic [LINE_W-1:0] i_rdata;
    logic              d_readmiss = 1'b0, d_writethru = 1'b0;
    logic [31:0]       d_addr = '0, d_wdata = '0;
    logic              d_readready, d_writeready;
    logic [LINE_W-1:0] d_rdata;
    logic              mem_req, mem_we;
    logic [31:0]       mem_addr, mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  conflict_cnt;
    stateT             dbgState;

    int passCount  = 0;
    int totalCount = 0;

    // Expected memory transactions: {we, addr, wdata}
    logic [64:0] exp_q[$];
    logic        reqPrev = 1'b0;

    mem_arbiter #(.LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .i_readmiss(i_readmiss), .i_addr(i_addr), .i_abort(i_abort),
        .i_readready(i_readready), .i_rdata(i_rdata),
        .d_readmiss(d_readmiss), .d_writethru(d_writethru), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_readready(d_readready), .d_writeready(d_writeready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .conflict_cnt(conflict_cnt), .dbgState(dbgState)
    );

    // Clock
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        totalCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every new memory transaction is compared with the head of exp_q.
    always @(negedge Clk) begin
        if (mem_req && !reqPrev) begin
            if (exp_q.size() == 0) begin
                check("txn_unexpected", {mem_we, mem_addr}, 0);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                check("txn_we", mem_we, e[64]);
                check("txn_addr", mem_addr, e[63:32]);
                if (e[64]) check("txn_wdata", mem_wdata, e[31:0]);
            end
        end
        reqPrev = mem_req;
    end

    task automatic applyReset();
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
    endtask

    task automatic waitMemReq(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("mem_req_timeout", 0, 1);
    endtask

    // Memory responder: mem_ready for one cycle, `delay` cycles after mem_req is first seen.
    task automatic serveMem(input int delay, input logic [LINE_W-1:0] line);
        bit ok;
        waitMemReq(ok);
        if (ok) begin
            repeat (delay) @(negedge Clk);
            mem_ready = 1'b1;
            mem_rdata = line;
            @(posedge Clk);
            #1 mem_ready = 1'b0;
        end
    endtask

    task automatic finishResp(input string tag, input logic expI, input logic expDr, input logic expDw);
        @(negedge Clk);
        check({tag, "_i_readready"}, i_readready, expI);
        check({tag, "_d_readready"}, d_readready, expDr);
        check({tag, "_d_writeready"}, d_writeready, expDw);
    endtask

    initial begin
        logic [LINE_W-1:0] l1, l2a, l2b, l2c, l3, l4a, l4b, l5a, l5b, l6;
        l1  = 128'h1111_0000_2222_0000_3333_0000_4444_0001;
        l2a = 128'h2A2A_0000_0000_0000_0000_0000_0000_00A2;
        l2b = 128'h2B2B_0000_0000_0000_0000_0000_0000_00B2;
        l2c = 128'h2C2C_0000_0000_0000_0000_0000_0000_00C2;
        l3  = 128'h3333_CAFE_0000_0000_0000_0000_0000_0003;
        l4a = 128'h4A4A_DEAD_0000_0000_0000_0000_0000_00A4;
        l4b = 128'h4B4B_BEEF_0000_0000_0000_0000_0000_00B4;
        l5a = 128'h5A5A_0000_0000_0000_0000_0000_0000_00A5;
        l5b = 128'h5B5B_0000_0000_0000_0000_0000_0000_00B5;
        l6  = 128'h6666_6666_0000_0000_0000_0000_0000_0006;

        applyReset();
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_conflict", conflict_cnt, 0);
        check("rst_state", dbgState, IDLE);

        // 1: lone icache miss, memory answers 3 cycles after mem_req
        exp_q.push_back({1'b0, 32'h0000_1230, 32'h0});
        i_readmiss = 1'b1; i_addr = 32'h0000_1234;
        serveMem(3, l1);
        finishResp("t1", 1, 0, 0);
        check("t1_busy_resp", busy, 1);
        check("t1_i_rdata", i_rdata, l1);
        i_readmiss = 1'b0;
        @(negedge Clk);
        check("t1_busy_idle", busy, 0);
        check("t1_pulse_gone", i_readready, 0);

        // 2: I/D tie after reset goes to I; I re-raised while D pending goes to D
        applyReset();
        exp_q.push_back({1'b0, 32'h0000_2000, 32'h0});
        exp_q.push_back({1'b0, 32'h0000_3000, 32'h0});
        exp_q.push_back({1'b0, 32'h0000_2040, 32'h0});
        i_readmiss = 1'b1; i_addr = 32'h0000_2000;
        d_readmiss = 1'b1; d_addr = 32'h0000_3008;
        serveMem(1, l2a);
        finishResp("t2a", 1, 0, 0);
        check("t2a_i_rdata", i_rdata, l2a);
        check("t2a_conflict", conflict_cnt, 1);
        i_readmiss = 1'b0;
        @(posedge Clk);
        #1 i_readmiss = 1'b1; i_addr = 32'h0000_2040;
        serveMem(0, l2b);
        finishResp("t2b", 0, 1, 0);
        check("t2b_d_rdata", d_rdata, l2b);
        check("t2b_conflict", conflict_cnt, 2);
        d_readmiss = 1'b0;
        serveMem(2, l2c);
        finishResp("t2c", 1, 0, 0);
        check("t2c_i_rdata", i_rdata, l2c);
        check("t2c_conflict", conflict_cnt, 2);
        i_readmiss = 1'b0;

        // 3: write-through ordered before the read to the same address
        exp_q.push_back({1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
        exp_q.push_back({1'b0, 32'h0000_0100, 32'h0});
        d_writethru = 1'b1; d_readmiss = 1'b1;
        d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        serveMem(1, l4a);
        finishResp("t3w", 0, 0, 1);
        check("t3w_d_rdata_kept", d_rdata, l2b);
        d_writethru = 1'b0;
        serveMem(1, l3);
        finishResp("t3r", 0, 1, 0);
        check("t3r_d_rdata", d_rdata, l3);
        d_readmiss = 1'b0;

        // 4: icache abort during ISSUE; pending D read granted next
        exp_q.push_back({1'b0, 32'h0000_4000, 32'h0});
        exp_q.push_back({1'b0, 32'h0000_5000, 32'h0});
        i_readmiss = 1'b1; i_addr = 32'h0000_4000;
        begin
            bit ok;
            waitMemReq(ok);
        end
        i_abort = 1'b1;
        d_readmiss = 1'b1; d_addr = 32'h0000_5000;
        @(posedge Clk);
        #1 i_abort = 1'b0; i_readmiss = 1'b0;
        serveMem(1, l4a);
        finishResp("t4a", 0, 0, 0);
        check("t4a_i_rdata_kept", i_rdata, l2c);
        serveMem(1, l4b);
        finishResp("t4b", 0, 1, 0);
        check("t4b_d_rdata", d_rdata, l4b);
        check("t4b_conflict", conflict_cnt, 2);
        d_readmiss = 1'b0;

        // 5: reset in the middle of ISSUE, then a tie goes to I
        exp_q.push_back({1'b0, 32'h0000_6000, 32'h0});
        i_readmiss = 1'b1; i_addr = 32'h0000_6000;
        begin
            bit ok;
            waitMemReq(ok);
        end
        Rst = 1'b0; i_readmiss = 1'b0;
        @(negedge Clk);
        check("t5_busy", busy, 0);
        check("t5_mem_req", mem_req, 0);
        check("t5_mem_we", mem_we, 0);
        check("t5_mem_addr", mem_addr, 0);
        check("t5_mem_wdata", mem_wdata, 0);
        check("t5_pulses", {i_readready, d_readready, d_writeready}, 0);
        check("t5_i_rdata", i_rdata, 0);
        check("t5_d_rdata", d_rdata, 0);
        check("t5_conflict", conflict_cnt, 0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        exp_q.push_back({1'b0, 32'h0000_7000, 32'h0});
        exp_q.push_back({1'b0, 32'h0000_7040, 32'h0});
        i_readmiss = 1'b1; i_addr = 32'h0000_7000;
        d_readmiss = 1'b1; d_addr = 32'h0000_7048;
        serveMem(1, l5a);
        finishResp("t5a", 1, 0, 0);
        check("t5a_i_rdata", i_rdata, l5a);
        i_readmiss = 1'b0;
        serveMem(1, l5b);
        finishResp("t5b", 0, 1, 0);
        check("t5b_d_rdata", d_rdata, l5b);
        check("t5b_conflict", conflict_cnt, 1);
        d_readmiss = 1'b0;

        // 6: mem_ready tied high, five back-to-back ties alternate I,D,I,D,I
        mem_ready = 1'b1; mem_rdata = l6;
        applyReset();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({1'b0, (k % 2 == 0) ? 32'h0000_8000 : 32'h0000_9010, 32'h0});
        end
        i_readmiss = 1'b1; i_addr = 32'h0000_8000;
        d_readmiss = 1'b1; d_addr = 32'h0000_901C;
        for (int c = 0; c < 15; c++) begin
            int phase, txn, expCnt;
            @(negedge Clk);
            phase  = c % 3;
            txn    = c / 3;
            expCnt = ((c + 2) / 3 > 3) ? 3 : (c + 2) / 3;
            check($sformatf("t6_c%0d_mem_req", c), mem_req, phase == 1);
            check($sformatf("t6_c%0d_i_readready", c), i_readready, (phase == 2) && (txn % 2 == 0));
            check($sformatf("t6_c%0d_d_readready", c), d_readready, (phase == 2) && (txn % 2 == 1));
            check($sformatf("t6_c%0d_conflict", c), conflict_cnt, expCnt);
            if (c == 14) begin
                i_readmiss = 1'b0;
                d_readmiss = 1'b0;
            end
        end
        @(negedge Clk);
        check("t6_busy_end", busy, 0);
        check("t6_conflict_sat", conflict_cnt, 3);
        check("t6_i_rdata", i_rdata, l6);
        check("t6_d_rdata", d_rdata, l6);
        mem_ready = 1'b0;
        repeat (2) @(negedge Clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
